// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch/jump resolution controller.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ_BRANCH = 2'b00,
    REQ_JAL    = 2'b01,
    REQ_JALR   = 2'b10,
    REQ_RSVD   = 2'b11
  } req_type_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EVAL    = 2'b01,
    ST_RESOLVE = 2'b10,
    ST_REDIR   = 2'b11
  } state_e;

endpackage

// File: rtl/branch_unit.sv
// Combinational RV32I branch condition evaluator; undefined funct3 is never taken.
module branch_unit
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            take_branch
);

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      F3_BEQ:  take_branch = (rs1_val == rs2_val);
      F3_BNE:  take_branch = (rs1_val != rs2_val);
      F3_BLT:  take_branch = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  take_branch = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: take_branch = (rs1_val <  rs2_val);
      F3_BGEU: take_branch = (rs1_val >= rs2_val);
      default: take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution controller with mispredict redirect.
// Optional counters enabled by BRANCH_CTRL_STATS_EN.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_type,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            exc_misaligned
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_e          state_q, state_d;
  req_type_e       type_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic            pred_q;
  logic            latch_en;

  logic            take_branch;
  logic            taken_c;
  logic [XLEN-1:0] target_c, link_c;

  logic            req_ready_d, resolve_valid_d, resolve_taken_d, link_valid_d;
  logic            redirect_valid_d, flush_d, exc_d;
  logic [XLEN-1:0] link_data_d, redirect_pc_d;

  branch_unit #(.XLEN(XLEN)) u_branch_unit (
    .funct3      (funct3_q),
    .rs1_val     (rs1_q),
    .rs2_val     (rs2_q),
    .take_branch (take_branch)
  );

  // Outcome of the latched request, consumed during EVAL
  always_comb begin
    taken_c  = 1'b0;
    target_c = pc_q + imm_q;
    link_c   = pc_q + XLEN'(32'd4);
    case (type_q)
      REQ_BRANCH: taken_c = take_branch;
      REQ_JAL:    taken_c = 1'b1;
      REQ_JALR: begin
        taken_c  = 1'b1;
        target_c = (rs1_q + imm_q) & ~XLEN'(32'd1);
      end
      default:    taken_c = 1'b0;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d          = state_q;
    latch_en         = 1'b0;
    resolve_valid_d  = 1'b0;
    resolve_taken_d  = 1'b0;
    link_valid_d     = 1'b0;
    link_data_d      = link_data;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = RESET_PC;
    flush_d          = 1'b0;
    exc_d            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          latch_en = 1'b1;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d         = ST_RESOLVE;
        resolve_valid_d = 1'b1;
        resolve_taken_d = taken_c;
        if (taken_c && (target_c[1:0] != 2'b00)) begin
          exc_d = 1'b1;
        end else begin
          if (type_q == REQ_JAL || type_q == REQ_JALR) begin
            link_valid_d = 1'b1;
            link_data_d  = link_c;
          end
          if (type_q != REQ_RSVD && taken_c != pred_q) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = taken_c ? target_c : link_c;
            flush_d          = 1'b1;
          end
        end
      end
      ST_RESOLVE, ST_REDIR: begin
        if (redirect_valid && !redirect_ready) begin
          state_d          = ST_REDIR;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = redirect_pc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready      <= 1'b1;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      link_valid     <= 1'b0;
      link_data      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      flush          <= 1'b0;
      exc_misaligned <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready      <= req_ready_d;
      resolve_valid  <= resolve_valid_d;
      resolve_taken  <= resolve_taken_d;
      link_valid     <= link_valid_d;
      link_data      <= link_data_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      exc_misaligned <= exc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q   <= REQ_BRANCH;
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      pred_q   <= 1'b0;
    end else if (latch_en) begin
      type_q   <= req_type_e'(req_type);
      funct3_q <= funct3;
      rs1_q    <= rs1_val;
      rs2_q    <= rs2_val;
      pc_q     <= pc;
      imm_q    <= imm;
      pred_q   <= pred_taken;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Saturating event counters, sampled while the outcome is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_taken       <= '0;
      stat_mispredicts <= '0;
    end else if (state_q == ST_RESOLVE) begin
      if (type_q == REQ_BRANCH && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (resolve_taken && stat_taken != 32'hFFFF_FFFF)
        stat_taken <= stat_taken + 32'd1;
      if (flush && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases plus randomized requests vs a reference model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_type;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, pc, imm;
  logic        pred_taken;
  logic        resolve_valid, resolve_taken, link_valid;
  logic [31:0] link_data;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, exc_misaligned;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredicts;
`endif

  int checks   = 0;
  int failures = 0;

  branch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .funct3         (funct3),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .pc             (pc),
    .imm            (imm),
    .pred_taken     (pred_taken),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .link_valid     (link_valid),
    .link_data      (link_data),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .exc_misaligned (exc_misaligned)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_taken       (stat_taken),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Architectural outcome of one request, straight from the ISA rules
  task automatic model(input logic [1:0] t, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im, input logic pt,
                       output logic tk, output logic mis, output logic lnk,
                       output logic rdr, output logic [31:0] rpc, output logic [31:0] lval);
    logic [31:0] tgt;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    tk = 1'b0;
    tgt = p + im;
    if (t == 2'd0) begin
      if      (f3 == 3'd0) tk = (a == b);
      else if (f3 == 3'd1) tk = (a != b);
      else if (f3 == 3'd4) tk = (sa < sb);
      else if (f3 == 3'd5) tk = (sa >= sb);
      else if (f3 == 3'd6) tk = (longint'(a) < longint'(b));
      else if (f3 == 3'd7) tk = (longint'(a) >= longint'(b));
    end else if (t == 2'd1) begin
      tk = 1'b1;
    end else if (t == 2'd2) begin
      tk = 1'b1;
      tgt = ((a + im) / 2) * 2;
    end
    lval = p + 32'd4;
    mis = tk && (tgt % 4 != 0);
    lnk = !mis && (t == 2'd1 || t == 2'd2);
    rdr = !mis && (t != 2'd3) && (tk != pt);
    rpc = tk ? tgt : lval;
  endtask

  task automatic do_req(input logic [1:0] t, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im, input logic pt,
                        input int stall, input logic spur);
    logic tk, mis, lnk, rdr;
    logic [31:0] rpc, lval;
    model(t, f3, a, b, p, im, pt, tk, mis, lnk, rdr, rpc, lval);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = t; funct3 = f3; rs1_val = a; rs2_val = b;
    pc = p; imm = im; pred_taken = pt; redirect_ready = (stall == 0);
    @(negedge clk);
    check("ready_eval", 32'(req_ready), 32'd0);
    check("no_early_resolve", 32'(resolve_valid), 32'd0);
    req_valid = spur;
    req_type = 2'(($urandom % 2) + 1); pred_taken = ~pt;
    rs1_val = $urandom; pc = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    check("resolve_valid", 32'(resolve_valid), 32'd1);
    check("resolve_taken", 32'(resolve_taken), 32'(tk));
    check("exc_misaligned", 32'(exc_misaligned), 32'(mis));
    check("link_valid", 32'(link_valid), 32'(lnk));
    if (lnk) check("link_data", link_data, lval);
    check("redirect_valid", 32'(redirect_valid), 32'(rdr));
    check("flush", 32'(flush), 32'(rdr));
    if (rdr) begin
      check("redirect_pc", redirect_pc, rpc);
      for (int i = 0; i <= stall; i++) begin
        if (i > 0) begin
          check("redir_hold_valid", 32'(redirect_valid), 32'd1);
          check("redir_hold_pc", redirect_pc, rpc);
          check("redir_hold_flush", 32'(flush), 32'd0);
          check("redir_ready_low", 32'(req_ready), 32'd0);
        end
        redirect_ready = (i >= stall);
        @(negedge clk);
      end
    end else begin
      @(negedge clk);
    end
    check("back_idle_ready", 32'(req_ready), 32'd1);
    check("pulse_cleared", 32'({resolve_valid, link_valid, flush, exc_misaligned, redirect_valid}), 32'd0);
    check("idle_pc", redirect_pc, 32'h0000_0000);
    redirect_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_pulses"}, 32'({resolve_valid, resolve_taken, link_valid, flush, exc_misaligned, redirect_valid}), 32'd0);
    check({tag, "_rpc"}, redirect_pc, 32'h0000_0000);
    check({tag, "_link"}, link_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_type = 2'd0; funct3 = 3'd0;
    rs1_val = '0; rs2_val = '0; pc = '0; imm = '0; pred_taken = 1'b0; redirect_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    do_req(2'd0, 3'b000, 32'h10, 32'h10, 32'h100, 32'h20, 1'b0, 0, 1'b0);          // BEQ mispredict
    do_req(2'd0, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h80, 32'h40, 1'b0, 0, 1'b0); // BLTU not taken
    do_req(2'd2, 3'b000, 32'h2003, 32'h0, 32'h40, 32'h4, 1'b1, 0, 1'b0);           // JALR misaligned
    do_req(2'd1, 3'b000, 32'h0, 32'h0, 32'h200, 32'hFFFF_FFF0, 1'b0, 3, 1'b0);     // JAL, stalled redirect
    do_req(2'd0, 3'b001, 32'h5, 32'h6, 32'h300, 32'h10, 1'b1, 0, 1'b1);            // BNE, spurious req
    do_req(2'd3, 3'b000, 32'h1, 32'h1, 32'h400, 32'h8, 1'b1, 0, 1'b0);             // reserved type
    do_req(2'd0, 3'b010, 32'h1, 32'h1, 32'h500, 32'h8, 1'b1, 1, 1'b0);             // invalid funct3

    // Reset in EVAL of a mispredicted BGE discards it
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd0; funct3 = 3'b101; rs1_val = 32'd5; rs2_val = 32'd3;
    pc = 32'h600; imm = 32'h40; pred_taken = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state("rst_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_state("rst_mid_after");
    end
    redirect_ready = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b, im;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) im = im & 32'hFFFF_FFFC;
      do_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, b,
             $urandom & 32'hFFFF_FFFC, im, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Multi-cycle branch/jump resolution controller for the RV32I core. It accepts one control-transfer request at a time from decode over a valid/ready handshake. It evaluates the condition and computes the target, then compares the outcome with the fetch-stage prediction. On a mispredict it issues a PC redirect with a one-cycle flush; for JAL/JALR it returns the link value.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, value driven on redirect_pc while idle/reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_type  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 reserved
funct3  in  3  branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
rs1_val  in  XLEN  operand 1
rs2_val  in  XLEN  operand 2
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended immediate
pred_taken  in  1  fetch prediction for this instruction
resolve_valid  out  1  one-cycle pulse: outcome known
resolve_taken  out  1  actual outcome, valid with resolve_valid
link_valid  out  1  one-cycle pulse for JAL/JALR: write link_data to rd
link_data  out  XLEN  pc+4
redirect_valid  out  1  redirect request, held until accepted
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  corrected PC
flush  out  1  one-cycle pulse on first redirect cycle
exc_misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1. All pulses are 0, redirect_valid=0, redirect_pc=RESET_PC, link_data=0.
- FSM states: IDLE, EVAL, RESOLVE, REDIR.
- IDLE: req_ready=1. Acceptance is req_valid&&req_ready (cycle T). On acceptance, latch all request fields and move to EVAL.
- EVAL (T+1): compare the latched operands and register these results:
  - taken: BRANCH uses the condition; invalid funct3 gives taken=0. JAL/JALR always taken.
  - target: BRANCH/JAL = pc+imm. JALR = (rs1+imm) & ~1.
  - link = pc+4.
  - All adds are modulo 2^XLEN; wrap-around is silent.
- RESOLVE (T+2):
  - resolve_valid=1 and resolve_taken=taken. For JAL/JALR, link_valid=1 and link_data=link.
  - If taken and target[1:0]!=0: exc_misaligned=1, with no redirect, no link_valid and no flush. Go to IDLE.
  - Else, if taken!=pred_taken: redirect_valid=1, redirect_pc = taken ? target : pc+4, flush=1. If redirect_ready=1 go to IDLE, otherwise go to REDIR.
  - Else (correct prediction): go to IDLE.
- REDIR: hold redirect_valid=1 with redirect_pc stable and flush=0. Go to IDLE in the cycle redirect_ready=1.
- Reserved req_type=11: resolve_valid=1, resolve_taken=0, no other effect.
- req_valid is ignored outside IDLE. Minimum spacing between accepted requests is 3 cycles.
- Reset asserted mid-operation aborts immediately: the in-flight request is discarded and no pulses follow.

Optional Feature:
BRANCH_CTRL_STATS_EN
- Defined: adds outputs stat_branches, stat_taken and stat_mispredicts (each 32 bits). They count in the RESOLVE cycle, saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: these ports and counters are absent.

Decomposition:
- Package branch_ctrl_pkg: req_type encodings, funct3 constants, FSM state encoding.
- Sub-module: reuse the existing combinational branch_unit (funct3, rs1_val, rs2_val → take_branch) for the EVAL compare. All sequencing stays in branch_ctrl.

Test Plan:
- BEQ, pc=0x100, imm=0x20, rs1=rs2=0x10, pred_taken=0 → T+2: resolve_taken=1, redirect_valid=1, redirect_pc=0x120, flush=1 for one cycle.
- BLTU, rs1=0x8000_0000, rs2=0x7FFF_FFFF, pred_taken=0 → resolve_taken=0, no redirect, req_ready=1 at T+3.
- JALR, rs1=0x2003, imm=0x4, pc=0x40, pred_taken=1 → target 0x2006 is misaligned: exc_misaligned pulse, no link_valid, no redirect.
- JAL, pc=0x200, imm=0xFFFF_FFF0, pred_taken=0, redirect_ready held low 3 cycles → redirect_pc=0x1F0 stable 4 cycles, flush only the first cycle, link_data=0x204 with link_valid.
- BNE, rs1≠rs2, pred_taken=1 → no redirect. A second req_valid pulsed during EVAL is ignored (req_ready=0).
- rst_n dropped in EVAL of a mispredicted BGE → no resolve_valid/redirect/flush afterward; outputs at reset values.
